// File: rtl/dlx_control_fsm.sv
// Multi-cycle DLX control unit: fetch/decode/execute/memory/writeback sequencing
// with a bounded memory wait and a sticky trap state for illegal opcodes and timeouts.
module dlx_control_fsm #(
    parameter int WAIT_LIMIT = 255,
    parameter int WAIT_W     = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] IR,
    input  logic        Zflag,
    input  logic        mem_ready,
    output logic [4:0]  ALUop,
    output logic [2:0]  s2op,
    output logic        s1_sel,
    output logic        mem_read,
    output logic        mem_write,
    output logic        addr_sel,
    output logic        IR_load,
    output logic        AB_load,
    output logic        PC_load,
    output logic        MAR_load,
    output logic        MDR_load,
    output logic        ALUout_load,
    output logic        reg_write,
    output logic        rd_sel,
    output logic        wb_sel,
    output logic        trap,
    output logic [1:0]  trap_cause,
    output logic [2:0]  state
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_BRANCH = 3'd5,
        S_TRAP   = 3'd7
    } state_t;

    typedef enum logic [2:0] {
        CLS_ALU_R, CLS_ALU_I, CLS_LW, CLS_SW, CLS_BEQZ, CLS_BNEZ, CLS_J, CLS_ILL
    } cls_t;

    localparam logic [4:0] ALU_ADD = 5'b00000;
    localparam logic [4:0] ALU_SUB = 5'b00001;
    localparam logic [4:0] ALU_AND = 5'b00010;
    localparam logic [4:0] ALU_OR  = 5'b00011;
    localparam logic [4:0] ALU_XOR = 5'b00100;

    localparam logic [2:0] S2_B      = 3'b000;
    localparam logic [2:0] S2_SIMM16 = 3'b001;
    localparam logic [2:0] S2_ZIMM16 = 3'b010;
    localparam logic [2:0] S2_SIMM26 = 3'b011;
    localparam logic [2:0] S2_FOUR   = 3'b100;
    localparam logic [2:0] S2_ZERO   = 3'b101;

    localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
    localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

    // Last count value at which a further non-ready cycle means the limit is reached.
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(WAIT_LIMIT - 1);

    function automatic cls_t classify(input logic [5:0] op, input logic [5:0] fn);
        case (op)
            6'h00: begin
                case (fn)
                    6'h20, 6'h22, 6'h24, 6'h25, 6'h26: classify = CLS_ALU_R;
                    default:                           classify = CLS_ILL;
                endcase
            end
            6'h08, 6'h0A, 6'h0C, 6'h0D, 6'h0E: classify = CLS_ALU_I;
            6'h23:   classify = CLS_LW;
            6'h2B:   classify = CLS_SW;
            6'h04:   classify = CLS_BEQZ;
            6'h05:   classify = CLS_BNEZ;
            6'h02:   classify = CLS_J;
            default: classify = CLS_ILL;
        endcase
    endfunction

    // R-type selects the operation by func, immediates by opcode; both map to one table.
    function automatic logic [4:0] alu_code(input logic [5:0] op, input logic [5:0] fn);
        logic [5:0] key;
        key = (op == 6'h00) ? fn : op;
        case (key)
            6'h22, 6'h0A: alu_code = ALU_SUB;
            6'h24, 6'h0C: alu_code = ALU_AND;
            6'h25, 6'h0D: alu_code = ALU_OR;
            6'h26, 6'h0E: alu_code = ALU_XOR;
            default:      alu_code = ALU_ADD;
        endcase
    endfunction

    function automatic logic [2:0] s2_code(input logic [5:0] op);
        case (op)
            6'h00:        s2_code = S2_B;
            6'h08, 6'h0A: s2_code = S2_SIMM16;
            default:      s2_code = S2_ZIMM16;
        endcase
    endfunction

    state_t            state_q, state_d;
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic [1:0]        trap_cause_q, trap_cause_d;
    cls_t              cls;
    logic              unused_ir_bits;

    assign cls            = classify(IR[31:26], IR[5:0]);
    assign unused_ir_bits = ^IR[25:6];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_FETCH;
            wait_cnt_q   <= '0;
            trap_cause_q <= 2'b00;
        end else begin
            state_q      <= state_d;
            wait_cnt_q   <= wait_cnt_d;
            trap_cause_q <= trap_cause_d;
        end
    end

    // The counter only runs while a FETCH/MEM access waits; every other path clears it.
    always_comb begin
        state_d      = state_q;
        wait_cnt_d   = '0;
        trap_cause_d = trap_cause_q;
        case (state_q)
            S_FETCH, S_MEM: begin
                if (mem_ready) begin
                    if (state_q == S_FETCH) state_d = S_DECODE;
                    else                    state_d = (cls == CLS_LW) ? S_WB : S_FETCH;
                end else if (wait_cnt_q == WAIT_LAST) begin
                    state_d      = S_TRAP;
                    trap_cause_d = CAUSE_TIMEOUT;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end
            S_DECODE: begin
                if (cls == CLS_ILL) begin
                    state_d      = S_TRAP;
                    trap_cause_d = CAUSE_ILLEGAL;
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                case (cls)
                    CLS_ALU_R, CLS_ALU_I: state_d = S_WB;
                    CLS_LW, CLS_SW:       state_d = S_MEM;
                    CLS_BEQZ:             state_d = Zflag ? S_BRANCH : S_FETCH;
                    CLS_BNEZ:             state_d = Zflag ? S_FETCH : S_BRANCH;
                    default:              state_d = S_FETCH;
                endcase
            end
            S_WB, S_BRANCH: state_d = S_FETCH;
            S_TRAP:         state_d = S_TRAP;
            default:        state_d = S_FETCH;
        endcase
    end

    always_comb begin
        ALUop       = ALU_ADD;
        s2op        = S2_B;
        s1_sel      = 1'b0;
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        addr_sel    = 1'b0;
        IR_load     = 1'b0;
        AB_load     = 1'b0;
        PC_load     = 1'b0;
        MAR_load    = 1'b0;
        MDR_load    = 1'b0;
        ALUout_load = 1'b0;
        reg_write   = 1'b0;
        rd_sel      = 1'b0;
        wb_sel      = 1'b0;
        if (!rst) begin
            case (state_q)
                S_FETCH: begin
                    mem_read = 1'b1;
                    IR_load  = mem_ready;
                end
                S_DECODE: begin
                    AB_load = 1'b1;
                    PC_load = 1'b1;
                    s1_sel  = 1'b1;
                    s2op    = S2_FOUR;
                end
                S_EXEC: begin
                    case (cls)
                        CLS_ALU_R, CLS_ALU_I: begin
                            ALUop       = alu_code(IR[31:26], IR[5:0]);
                            s2op        = s2_code(IR[31:26]);
                            ALUout_load = 1'b1;
                        end
                        CLS_LW, CLS_SW: begin
                            s2op     = S2_SIMM16;
                            MAR_load = 1'b1;
                        end
                        CLS_BEQZ, CLS_BNEZ: begin
                            ALUop = ALU_SUB;
                            s2op  = S2_ZERO;
                        end
                        CLS_J: begin
                            s1_sel  = 1'b1;
                            s2op    = S2_SIMM26;
                            PC_load = 1'b1;
                        end
                        default: ;
                    endcase
                end
                S_MEM: begin
                    addr_sel = 1'b1;
                    if (cls == CLS_LW) begin
                        mem_read = 1'b1;
                        MDR_load = mem_ready;
                    end else begin
                        mem_write = 1'b1;
                    end
                end
                S_WB: begin
                    reg_write = 1'b1;
                    rd_sel    = (cls != CLS_ALU_R);
                    wb_sel    = (cls == CLS_LW);
                end
                S_BRANCH: begin
                    s1_sel  = 1'b1;
                    s2op    = S2_SIMM16;
                    PC_load = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign trap       = (state_q == S_TRAP);
    assign trap_cause = trap_cause_q;
    assign state      = state_q;

endmodule
